// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if - stream bundle for the rr_mux_n multiplexer.
//
// Handshake rule for every channel (in and out): a word moves on a rising
// clk edge where valid and ready are both 1. A producer holds valid and its
// data stable until that edge. Ready may depend combinationally on valid.
//
// Signals:
//   mode, sel   : arbitration control (0 = round-robin, 1 = fixed channel sel)
//   in_data     : N packed words, channel i at [i*W +: W]
//   in_valid    : per-channel request
//   in_ready    : per-channel accept, one-hot or zero
//   out_data    : selected word
//   out_sel     : channel index of out_data
//   out_valid   : out_data holds a word
//   out_ready   : consumer accepts the word
//
// Modports: slave = the multiplexer, master = producers plus consumer.
interface rr_mux_n_if #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n - registered N-to-1 stream multiplexer with round-robin or
// fixed-select arbitration.
//
// One output slot (EMPTY/FULL). When the slot is free (EMPTY, or FULL and
// being drained this cycle) one requesting channel is granted; its word and
// index are registered into the slot. Drain and refill can happen in the
// same cycle, so a steady stream moves one word per cycle.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus       : rr_mux_n_if slave modport (inputs, per-channel ready, output)
//   dbg_state : current slot state (0 = EMPTY, 1 = FULL)
//   dbg_ptr   : round-robin search start channel
//   xfer_cnt  : saturating count of output handshakes
//               (present only when RR_MUX_CNT_EN is defined)
//
// Build option: define RR_MUX_CNT_EN to add the xfer_cnt port and counter.
module rr_mux_n #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  rr_mux_n_if.slave     bus,
  output logic          dbg_state,
  output logic [SW-1:0] dbg_ptr
`ifdef RR_MUX_CNT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;

  logic            slot_free;
  logic            gnt_found;
  logic [SW-1:0]   gnt_idx;
  logic            grant;
  logic [W-1:0]    gnt_word;
  // in_valid zero-extended to every encodable sel value, so a sel >= N
  // reads a 0 instead of an out-of-range X.
  logic [(1<<SW)-1:0] valid_pad;
  int              idx;

  assign slot_free = (state == EMPTY) || bus.out_ready;

  always_comb begin
    valid_pad = '0;
    for (int i = 0; i < N; i++) valid_pad[i] = bus.in_valid[i];

    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (bus.mode) begin
      if (valid_pad[bus.sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = bus.sel;
      end
    end else begin
      // First requester at or after ptr, wrapping past N-1 back to 0.
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_found && bus.in_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = SW'(idx);
        end
      end
    end
  end

  // No grant while in reset so in_ready reads zero as soon as rst rises.
  assign grant    = gnt_found && slot_free && !rst;
  assign gnt_word = bus.in_data[int'(gnt_idx)*W +: W];

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++)
      bus.in_ready[i] = grant && (gnt_idx == SW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      ptr          <= '0;
      bus.out_data <= '0;
      bus.out_sel  <= '0;
    end else if (grant) begin
      state        <= FULL;
      bus.out_data <= gnt_word;
      bus.out_sel  <= gnt_idx;
      if (!bus.mode)
        ptr <= (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end else if (state == FULL && bus.out_ready) begin
      // Drained with nothing to refill: data and index keep last values.
      state <= EMPTY;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign dbg_state     = state;
  assign dbg_ptr       = ptr;

`ifdef RR_MUX_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (bus.out_valid && bus.out_ready && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n - directed testbench for rr_mux_n (N=8, W=8).
// Inputs change 1 ns after a rising edge; outputs are checked at that
// point, i.e. well away from the next active edge.
module tb_rr_mux_n;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          dbg_state;
  logic [SW-1:0] dbg_ptr;
`ifdef RR_MUX_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  rr_mux_n_if #(.N(N), .W(W), .SW(SW)) bus ();

  rr_mux_n #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
`ifdef RR_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every channel carries 8'h10 + channel number.
  task automatic drive_default_data();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    drive_default_data();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    checks++; if (bus.out_sel !== 3'd0) begin failures++; $display("FAIL reset_out_sel got=%0h exp=0", bus.out_sel); end
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", bus.in_ready); end
    checks++; if (dbg_ptr !== 3'd0) begin failures++; $display("FAIL reset_ptr got=%0h exp=0", dbg_ptr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 8'h01) begin failures++; $display("FAIL post_reset_in_ready got=%0h exp=01", bus.in_ready); end
  endtask

  // All channels valid, out_ready high: grants 0..7,0 with one word per cycle.
  task automatic test_rr_fairness();
    logic [2:0] e_sel;
    logic [7:0] e_rdy;
    for (int k = 0; k < 9; k++) begin
      e_sel = 3'(k % N);
      e_rdy = 8'h01 << ((k + 1) % N);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%0h exp=1", k, bus.out_valid); end
      checks++; if (bus.out_sel !== e_sel) begin failures++; $display("FAIL rr_sel[%0d] got=%0h exp=%0h", k, bus.out_sel, e_sel); end
      checks++; if (bus.out_data !== 8'h10 + 8'(e_sel)) begin failures++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, bus.out_data, 8'h10 + 8'(e_sel)); end
      checks++; if (bus.in_ready !== e_rdy) begin failures++; $display("FAIL rr_in_ready[%0d] got=%0h exp=%0h", k, bus.in_ready, e_rdy); end
    end
  endtask

  // Move ptr to 6 via a lone request on channel 5, then channels 0 and 2.
  task automatic test_wrap_skip();
    logic [2:0] exp_sel [3];
    logic [2:0] exp_ptr [3];
    exp_sel = '{3'd0, 3'd2, 3'd0};
    exp_ptr = '{3'd1, 3'd3, 3'd1};
    bus.in_valid = 8'h20;
    step();
    checks++; if (bus.out_sel !== 3'd5) begin failures++; $display("FAIL wrap_setup_sel got=%0h exp=5", bus.out_sel); end
    checks++; if (dbg_ptr !== 3'd6) begin failures++; $display("FAIL wrap_setup_ptr got=%0h exp=6", dbg_ptr); end
    bus.in_valid = 8'b0000_0101;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.out_sel !== exp_sel[k]) begin failures++; $display("FAIL wrap_sel[%0d] got=%0h exp=%0h", k, bus.out_sel, exp_sel[k]); end
      checks++; if (dbg_ptr !== exp_ptr[k]) begin failures++; $display("FAIL wrap_ptr[%0d] got=%0h exp=%0h", k, dbg_ptr, exp_ptr[k]); end
    end
  endtask

  // Slot holds channel 0's word; stall 4 cycles, then release.
  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL bp_in_ready_now got=%0h exp=0", bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0h exp=1", k, bus.out_valid); end
      checks++; if (bus.out_data !== 8'h10) begin failures++; $display("FAIL bp_data[%0d] got=%0h exp=10", k, bus.out_data); end
      checks++; if (bus.out_sel !== 3'd0) begin failures++; $display("FAIL bp_sel[%0d] got=%0h exp=0", k, bus.out_sel); end
      checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", k, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'h04) begin failures++; $display("FAIL bp_release_ready got=%0h exp=04", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0h exp=1", bus.out_valid); end
    checks++; if (bus.out_sel !== 3'd2) begin failures++; $display("FAIL bp_next_sel got=%0h exp=2", bus.out_sel); end
    checks++; if (bus.out_data !== 8'h12) begin failures++; $display("FAIL bp_next_data got=%0h exp=12", bus.out_data); end
  endtask

  // ptr is 3 here; fixed mode on channel 3 must leave it at 3.
  task automatic test_fixed();
    bus.mode     = 1'b1;
    bus.sel      = 3'd3;
    bus.in_valid = 8'hFF;
    #1;
    checks++; if (bus.in_ready !== 8'h08) begin failures++; $display("FAIL fix_in_ready got=%0h exp=08", bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.out_sel !== 3'd3) begin failures++; $display("FAIL fix_sel[%0d] got=%0h exp=3", k, bus.out_sel); end
      checks++; if (bus.out_data !== 8'h13) begin failures++; $display("FAIL fix_data[%0d] got=%0h exp=13", k, bus.out_data); end
      checks++; if (dbg_ptr !== 3'd3) begin failures++; $display("FAIL fix_ptr[%0d] got=%0h exp=3", k, dbg_ptr); end
      checks++; if (bus.in_ready !== 8'h08) begin failures++; $display("FAIL fix_ready[%0d] got=%0h exp=08", k, bus.in_ready); end
    end
    bus.sel      = 3'd7;
    bus.in_valid = 8'h7F;
    #1;
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL fix7_in_ready got=%0h exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fix7_drain_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h13) begin failures++; $display("FAIL fix7_hold_data got=%0h exp=13", bus.out_data); end
    checks++; if (bus.out_sel !== 3'd3) begin failures++; $display("FAIL fix7_hold_sel got=%0h exp=3", bus.out_sel); end
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL fix7_empty_ready got=%0h exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fix7_stay_empty got=%0h exp=0", bus.out_valid); end
  endtask

  // Reset between edges with a word held; outputs clear before any edge.
  task automatic test_mid_reset();
    bus.mode     = 1'b0;
    bus.in_valid = 8'hFF;
    step();
    checks++; if (bus.out_sel !== 3'd3) begin failures++; $display("FAIL mr_pre_sel got=%0h exp=3", bus.out_sel); end
    checks++; if (dbg_ptr !== 3'd4) begin failures++; $display("FAIL mr_pre_ptr got=%0h exp=4", dbg_ptr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL mr_data got=%0h exp=0", bus.out_data); end
    checks++; if (bus.out_sel !== 3'd0) begin failures++; $display("FAIL mr_sel got=%0h exp=0", bus.out_sel); end
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL mr_in_ready got=%0h exp=0", bus.in_ready); end
    checks++; if (dbg_ptr !== 3'd0) begin failures++; $display("FAIL mr_ptr got=%0h exp=0", dbg_ptr); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 8'h01) begin failures++; $display("FAIL mr_first_ready got=%0h exp=01", bus.in_ready); end
    step();
    checks++; if (bus.out_sel !== 3'd0) begin failures++; $display("FAIL mr_first_sel got=%0h exp=0", bus.out_sel); end
    checks++; if (bus.out_data !== 8'h10) begin failures++; $display("FAIL mr_first_data got=%0h exp=10", bus.out_data); end
  endtask

`ifdef RR_MUX_CNT_EN
  // Edge 1 after reset fills the slot; edges 2..21 are 20 output handshakes.
  task automatic test_counter();
    rst = 1'b1;
    #1;
    checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL cnt_reset got=%0h exp=0", xfer_cnt); end
    step();
    rst = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    repeat (21) step();
    checks++; if (xfer_cnt !== 16'd20) begin failures++; $display("FAIL cnt_20 got=%0d exp=20", xfer_cnt); end
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    repeat (3) step();
    checks++; if (xfer_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat got=%0h exp=ffff", xfer_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_fairness();
    test_wrap_skip();
    test_backpressure();
    test_fixed();
    test_mid_reset();
`ifdef RR_MUX_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
